mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single synchronous memory port between two requesters: the core's fetch/load/store path (`core_*`) and an auxiliary master such as a program loader or debug port (`aux_*`). Each cycle it grants at most one requester, muxes that requester's address, write enable, func3 and write data onto the port, and routes the one-cycle-late read data back to the requester that issued the read. The block sits between the core sequencer and the memory module; neither requester talks to memory directly.

## Interface
- `STARVE_LIMIT`, default 4: consecutive core grants allowed while aux waits before aux is forced in. Used only with `MEM_ARB_FAIR_EN`. Range 1..15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `core_req` input 1: core requests an access this cycle.
- `core_wen` input 1: 1 = store, 0 = read.
- `core_addr` input 32: byte address.
- `core_func3` input 3: access size/sign, passed through to memory.
- `core_wd` input 32: store data.
- `core_gnt` output 1: core access accepted this cycle.
- `core_rvalid` output 1: `core_rd` holds data for the core's read from the previous cycle.
- `core_rd` output 32: read data.
- `aux_req`, `aux_wen`, `aux_addr`, `aux_func3`, `aux_wd`, `aux_gnt`, `aux_rvalid`, `aux_rd`: same as the core ports, for aux.
- `aux_lock` input 1: keeps ownership with aux for a multi-beat sequence.
- `mem_wen` output 1: write strobe to memory.
- `mem_addr` output 32: read/write address.
- `mem_func3` output 3: access size.
- `mem_wd` output 32: write data.
- `mem_rd` input 32: memory read data, valid one cycle after the address is presented.

## Operation
- Grant is combinational in the same cycle.
  - An access is accepted when `req & gnt`.
  - Acceptance drives the `mem_*` outputs.
  - At most one `*_gnt` is high in any cycle.
- Default priority is fixed: the core wins over aux.
- Lock state, a single register `locked`:
  - Set when aux is granted with `aux_lock=1`.
  - While `locked` is set: aux has absolute priority and the core gets no grant, even if aux is idle.
  - Cleared on the first cycle with `aux_lock=0`. The core may be granted in that same cycle.
- Response tracking uses a register `rsp_owner` ∈ {NONE, CORE, AUX}.
  - Loaded on every accepted read with the granted requester.
  - Set to NONE on an accepted write or an idle cycle.
  - `*_rvalid` is high for exactly one cycle, only for the recorded owner.
  - `core_rd` and `aux_rd` both carry `mem_rd`. Consumers qualify them with their own `rvalid`.
- No grant this cycle:
  - `mem_wen` = 0.
  - `mem_addr` holds its last granted value (a registered copy), so memory is not disturbed.
  - `mem_func3` = 3'b010.
- Width rules: all widths pass through unchanged. No address arithmetic is done in the block.

## Timing
- Reset (synchronous, while `reset=1` and on the edge):
  - All `*_gnt` = 0, `mem_wen` = 0.
  - `mem_addr` register = 0, `mem_func3` = 3'b010.
  - `rsp_owner` = NONE, so both `*_rvalid` = 0.
  - `locked` = 0, starvation counter = 0.
- Reset asserted mid-lock or with a read in flight: the pending `rvalid` is dropped and the lock is released.
- Read latency:
  - Request accepted in cycle N → `*_rvalid` and data in cycle N+1.
  - Back-to-back reads from alternating requesters are supported at full rate: one accept per cycle, responses in order.
- Write: accepted in cycle N with `mem_wen=1` in the same cycle. No response.
- A requester must hold its `req`, `addr`, `wen`, `func3` and `wd` stable until granted.
- Simultaneous `core_req` and `aux_req` with no lock and no starvation force → the core is granted.

## Configuration
- `MEM_ARB_FAIR_EN` defined:
  - A 4-bit counter increments on each core grant made while `aux_req=1`.
  - It clears on any aux grant or when `aux_req=0`.
  - When the count equals `STARVE_LIMIT`, the next contested cycle grants aux, and the counter clears.
- `MEM_ARB_FAIR_EN` undefined: no counter is built. Priority is pure fixed core-first, and aux can starve indefinitely.

## Test plan
- Reset:
  - Stimulus: hold `reset` 2 cycles with both `req=1`.
  - Required: both `gnt`=0, both `rvalid`=0, `mem_wen`=0, `mem_func3`=3'b010 throughout.
- Core read then aux read:
  - Stimulus: core reads 0x100 in cycle 1, aux reads 0x200 in cycle 2, memory returns 0xAAAA then 0xBBBB.
  - Required: `core_rvalid` in cycle 2 with 0xAAAA; `aux_rvalid` in cycle 3 with 0xBBBB; never both in the same cycle.
- Contention:
  - Stimulus: both request reads continuously for 8 cycles, macro undefined.
  - Required: `core_gnt`=1 all 8 cycles; `aux_gnt`=0 all 8 cycles.
- Fairness:
  - Stimulus: same as contention, `MEM_ARB_FAIR_EN` defined, `STARVE_LIMIT`=4.
  - Required: grants are C,C,C,C,A,C,C,C,C,A…
- Lock:
  - Stimulus: aux write with `aux_lock=1` to 0x40 and 0x44, core requesting throughout, then `aux_lock=0`.
  - Required: `core_gnt`=0 for both locked cycles; core is granted in the cycle `aux_lock` drops.
- Reset mid-sequence:
  - Stimulus: assert `reset` in the cycle after an accepted aux read while locked.
  - Required: `aux_rvalid` stays 0; after reset the core is granted on the first request.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single synchronous memory port between the core
// path (core_*) and an auxiliary master (aux_*). Fixed core-first priority, an
// aux ownership lock for multi-beat sequences, and one-cycle read response routing.
// Optional build macro MEM_ARB_FAIR_EN adds a starvation counter that forces an
// aux grant after STARVE_LIMIT consecutive contested core grants.

module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        core_req,
    input  logic        core_wen,
    input  logic [31:0] core_addr,
    input  logic [2:0]  core_func3,
    input  logic [31:0] core_wd,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rd,

    input  logic        aux_req,
    input  logic        aux_wen,
    input  logic [31:0] aux_addr,
    input  logic [2:0]  aux_func3,
    input  logic [31:0] aux_wd,
    input  logic        aux_lock,
    output logic        aux_gnt,
    output logic        aux_rvalid,
    output logic [31:0] aux_rd,

    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_func3,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        RspNone,
        RspCore,
        RspAux
    } rsp_owner_e;

    localparam logic [2:0] Func3Idle = 3'b010;

    rsp_owner_e  rsp_owner_q, rsp_owner_d;
    logic        locked_q, locked_d;
    logic [31:0] addr_q, addr_d;
    logic        core_block;
    logic        aux_force;

    // The lock only blocks the core while aux keeps aux_lock high; dropping it
    // releases the port in the same cycle.
    assign core_block = locked_q & aux_lock;

`ifdef MEM_ARB_FAIR_EN
    localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign aux_force = aux_req & (starve_cnt_q == StarveLimit);

    // Count core grants won while aux waits; any aux grant or aux going idle clears.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (aux_gnt || !aux_req) begin
            starve_cnt_d = 4'd0;
        end else if (core_gnt) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_starve_limit;

    assign aux_force           = 1'b0;
    assign unused_starve_limit = ^(4'(STARVE_LIMIT));
`endif

    // Grant decision: lock and starvation force override core-first priority.
    always_comb begin
        core_gnt = 1'b0;
        aux_gnt  = 1'b0;
        if (!reset) begin
            if (core_req && !core_block && !aux_force) begin
                core_gnt = 1'b1;
            end else if (aux_req) begin
                aux_gnt = 1'b1;
            end
        end
    end

    // Port mux; with no grant the address holds so memory sees no change.
    always_comb begin
        mem_wen   = 1'b0;
        mem_addr  = addr_q;
        mem_func3 = Func3Idle;
        mem_wd    = 32'd0;
        addr_d    = addr_q;
        if (core_gnt) begin
            mem_wen   = core_wen;
            mem_addr  = core_addr;
            mem_func3 = core_func3;
            mem_wd    = core_wd;
            addr_d    = core_addr;
        end else if (aux_gnt) begin
            mem_wen   = aux_wen;
            mem_addr  = aux_addr;
            mem_func3 = aux_func3;
            mem_wd    = aux_wd;
            addr_d    = aux_addr;
        end
    end

    // Next lock and response owner.
    always_comb begin
        locked_d    = aux_lock & (locked_q | aux_gnt);
        rsp_owner_d = RspNone;
        if (core_gnt && !core_wen) begin
            rsp_owner_d = RspCore;
        end else if (aux_gnt && !aux_wen) begin
            rsp_owner_d = RspAux;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_owner_q <= RspNone;
            locked_q    <= 1'b0;
            addr_q      <= 32'd0;
        end else begin
            rsp_owner_q <= rsp_owner_d;
            locked_q    <= locked_d;
            addr_q      <= addr_d;
        end
    end

    // Reset drops any in-flight response immediately.
    assign core_rvalid = (rsp_owner_q == RspCore) & ~reset;
    assign aux_rvalid  = (rsp_owner_q == RspAux) & ~reset;
    assign core_rd     = mem_rd;
    assign aux_rd      = mem_rd;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter. Inputs are driven on the falling
// edge and outputs compared 1 ns later, before the next rising edge.

module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        core_req, core_wen, core_gnt, core_rvalid;
    logic [31:0] core_addr, core_wd, core_rd;
    logic [2:0]  core_func3;
    logic        aux_req, aux_wen, aux_lock, aux_gnt, aux_rvalid;
    logic [31:0] aux_addr, aux_wd, aux_rd;
    logic [2:0]  aux_func3;
    logic        mem_wen;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic [2:0]  mem_func3;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_wen    (core_wen),
        .core_addr   (core_addr),
        .core_func3  (core_func3),
        .core_wd     (core_wd),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rd     (core_rd),
        .aux_req     (aux_req),
        .aux_wen     (aux_wen),
        .aux_addr    (aux_addr),
        .aux_func3   (aux_func3),
        .aux_wd      (aux_wd),
        .aux_lock    (aux_lock),
        .aux_gnt     (aux_gnt),
        .aux_rvalid  (aux_rvalid),
        .aux_rd      (aux_rd),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_func3   (mem_func3),
        .mem_wd      (mem_wd),
        .mem_rd      (mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [2:0]  CoreF3 = 3'b001;
    localparam logic [2:0]  AuxF3  = 3'b100;
    localparam logic [31:0] CoreWdKey = 32'hC0DE0000;
    localparam logic [31:0] AuxWdKey  = 32'hA0A00000;

    typedef struct {
        logic        rst;
        logic        creq;
        logic        cwen;
        logic [31:0] caddr;
        logic        areq;
        logic        awen;
        logic [31:0] aaddr;
        logic        alock;
        logic [31:0] mrd;
        logic        cg;
        logic        ag;
        logic        crv;
        logic        arv;
        logic        mwen;
        logic [31:0] maddr;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cur    = 0;

    function automatic vec_t mk(input logic rst, input logic creq, input logic cwen,
                                input logic [31:0] caddr, input logic areq,
                                input logic awen, input logic [31:0] aaddr,
                                input logic alock, input logic [31:0] mrd,
                                input logic cg, input logic ag, input logic crv,
                                input logic arv, input logic mwen,
                                input logic [31:0] maddr);
        vec_t v;
        v.rst = rst;   v.creq = creq; v.cwen = cwen;   v.caddr = caddr;
        v.areq = areq; v.awen = awen; v.aaddr = aaddr; v.alock = alock;
        v.mrd = mrd;   v.cg = cg;     v.ag = ag;       v.crv = crv;
        v.arv = arv;   v.mwen = mwen; v.maddr = maddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, cur, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        logic [2:0]  exp_f3;
        logic [31:0] exp_wd;
        @(negedge clk);
        reset      = t.rst;
        core_req   = t.creq;
        core_wen   = t.cwen;
        core_addr  = t.caddr;
        core_func3 = CoreF3;
        core_wd    = t.caddr ^ CoreWdKey;
        aux_req    = t.areq;
        aux_wen    = t.awen;
        aux_addr   = t.aaddr;
        aux_func3  = AuxF3;
        aux_wd     = t.aaddr ^ AuxWdKey;
        aux_lock   = t.alock;
        mem_rd     = t.mrd;
        #1;
        exp_f3 = t.cg ? CoreF3 : (t.ag ? AuxF3 : 3'b010);
        exp_wd = t.cg ? (t.caddr ^ CoreWdKey) : (t.aaddr ^ AuxWdKey);
        chk("core_gnt", {31'd0, core_gnt}, {31'd0, t.cg});
        chk("aux_gnt", {31'd0, aux_gnt}, {31'd0, t.ag});
        chk("core_rvalid", {31'd0, core_rvalid}, {31'd0, t.crv});
        chk("aux_rvalid", {31'd0, aux_rvalid}, {31'd0, t.arv});
        chk("mem_wen", {31'd0, mem_wen}, {31'd0, t.mwen});
        chk("mem_addr", mem_addr, t.maddr);
        chk("mem_func3", {29'd0, mem_func3}, {29'd0, exp_f3});
        if (t.cg || t.ag) chk("mem_wd", mem_wd, exp_wd);
        if (t.crv) chk("core_rd", core_rd, t.mrd);
        if (t.arv) chk("aux_rd", aux_rd, t.mrd);
        cur++;
    endtask

    initial begin
        logic        exp_a;
        logic        prev_c, prev_a;
        logic [31:0] last_addr;

        reset = 1'b1;
        core_req = 1'b1; core_wen = 1'b0; core_addr = 32'h10; core_func3 = CoreF3;
        core_wd = 32'd0;
        aux_req = 1'b1; aux_wen = 1'b0; aux_addr = 32'h20; aux_func3 = AuxF3;
        aux_wd = 32'd0; aux_lock = 1'b0; mem_rd = 32'd0;
        @(posedge clk);

        //            rst c  cw caddr   a  aw aaddr   lk mrd         cg ag crv arv mw maddr
        // Reset held two more cycles with both requesting.
        vecs.push_back(mk(1, 1, 0, 32'h10,  1, 0, 32'h20,  0, 32'h0,    0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h10,  1, 0, 32'h20,  0, 32'h0,    0, 0, 0, 0, 0, 32'h0));
        // Core read 0x100, then aux read 0x200, responses routed one cycle late.
        vecs.push_back(mk(0, 1, 0, 32'h100, 0, 0, 32'h0,   0, 32'h0,    1, 0, 0, 0, 0, 32'h100));
        vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 32'h200, 0, 32'hAAAA, 0, 1, 1, 0, 0, 32'h200));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'hBBBB, 0, 0, 0, 1, 0, 32'h200));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,    0, 0, 0, 0, 0, 32'h200));
        // Alternating back-to-back reads at full rate.
        vecs.push_back(mk(0, 1, 0, 32'h300, 1, 0, 32'h304, 0, 32'h0,    1, 0, 0, 0, 0, 32'h300));
        vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 32'h304, 0, 32'h1111, 0, 1, 1, 0, 0, 32'h304));
        vecs.push_back(mk(0, 1, 0, 32'h308, 0, 0, 32'h0,   0, 32'h2222, 1, 0, 0, 1, 0, 32'h308));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h3333, 0, 0, 1, 0, 0, 32'h308));
        // Writes: strobe in the accept cycle, no response afterwards.
        vecs.push_back(mk(0, 1, 1, 32'h50,  0, 0, 32'h0,   0, 32'h0,    1, 0, 0, 0, 1, 32'h50));
        vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h54,  0, 32'h0,    0, 1, 0, 0, 1, 32'h54));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h5A5A, 0, 0, 0, 0, 0, 32'h54));

        // Continuous contention: core always wins unless the fairness build forces aux.
        prev_c = 1'b0;
        prev_a = 1'b0;
        last_addr = 32'h54;
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_FAIR_EN
            exp_a = ((i % 5) == 4);
`else
            exp_a = 1'b0;
`endif
            last_addr = exp_a ? 32'h64 : 32'h60;
            vecs.push_back(mk(0, 1, 0, 32'h60, 1, 0, 32'h64, 0, 32'h7000 + i,
                              !exp_a, exp_a, prev_c, prev_a, 0, last_addr));
            prev_c = !exp_a;
            prev_a = exp_a;
        end
        vecs.push_back(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h7777,
                          0, 0, prev_c, prev_a, 0, last_addr));

        foreach (vecs[i]) apply(vecs[i]);

        // Lock: aux takes the port with aux_lock, core blocked even while aux idles,
        // and core is granted in the cycle aux_lock drops.
        apply(mk(0, 0, 0, 32'h0,  1, 1, 32'h40, 1, 32'h0,    0, 1, 0, 0, 1, 32'h40));
        apply(mk(0, 1, 0, 32'h80, 1, 1, 32'h44, 1, 32'h0,    0, 1, 0, 0, 1, 32'h44));
        apply(mk(0, 1, 0, 32'h80, 0, 0, 32'h0,  1, 32'h0,    0, 0, 0, 0, 0, 32'h44));
        apply(mk(0, 1, 0, 32'h80, 0, 0, 32'h0,  0, 32'h0,    1, 0, 0, 0, 0, 32'h80));
        apply(mk(0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 32'h4444, 0, 0, 1, 0, 0, 32'h80));

        // Reset right after a locked aux read: response dropped, lock released.
        apply(mk(0, 0, 0, 32'h0,  1, 0, 32'h90, 1, 32'h0,    0, 1, 0, 0, 0, 32'h90));
        apply(mk(1, 1, 0, 32'hA0, 1, 0, 32'h94, 1, 32'h5555, 0, 0, 0, 0, 0, 32'h90));
        apply(mk(0, 1, 0, 32'hA0, 1, 0, 32'h94, 1, 32'h0,    1, 0, 0, 0, 0, 32'hA0));
        apply(mk(0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 32'h6666, 0, 0, 1, 0, 0, 32'hA0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
